// File: rtl/lcd_timing_gen.sv
// LCD/VGA raster timing generator with four built-in test patterns (black, bars, moving box, grid).
// Latency: every output is one VGA_CLK behind the counters; free-running, no backpressure.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter bit DE_POL   = 1'b1,
  parameter int BOX      = 32
) (
  input  logic        VGA_CLK,
  input  logic        RESET,
  input  logic [1:0]  MODE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DEN,
  output logic [9:0]  XPOS,
  output logic [9:0]  YPOS,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic [15:0] FRAME,
  output logic        LINE_START,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int BX_MAX  = (H_ACTIVE > BOX) ? H_ACTIVE - BOX : 0;
  localparam int BY_MAX  = (V_ACTIVE > BOX) ? V_ACTIVE - BOX : 0;

  logic [HW-1:0] hcnt, bx;
  logic [VW-1:0] vcnt, by;
  logic [1:0]    mode_r, mode_eff;
  logic          started;

  // 32-bit views keep all parameter comparisons free of width games
  logic [31:0] h, v, bx32, by32, bar_full;
  logic [2:0]  bar;
  logic        h_last, v_last, frame_first;
  logic        hs_act, vs_act, den_act, in_box;
  logic [15:0] pix;

  assign h    = 32'(hcnt);
  assign v    = 32'(vcnt);
  assign bx32 = 32'(bx);
  assign by32 = 32'(by);

  assign h_last      = (h == H_TOTAL - 1);
  assign v_last      = (v == V_TOTAL - 1);
  assign frame_first = (hcnt == '0) && (vcnt == '0);

  assign hs_act  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
  assign vs_act  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
  assign den_act = (h < H_ACTIVE) && (v < V_ACTIVE);
  assign in_box  = (h >= bx32) && (h < bx32 + BOX) && (v >= by32) && (v < by32 + BOX);

  // The first pixel of a frame already uses the freshly sampled MODE
  assign mode_eff = frame_first ? MODE : mode_r;

  always_comb begin
    bar_full = h / BAR_W;
    bar      = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];
    pix      = 16'h0000;
    case (mode_eff)
      2'd1:    pix = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
      2'd2:    pix = in_box ? 16'hFFFF : 16'h0000;
      2'd3:    pix = ((h[3:0] == 4'd0) || (v[3:0] == 4'd0)) ? 16'hFFFF : 16'h0000;
      default: pix = 16'h0000;
    endcase
    if (!den_act) pix = 16'h0000;
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      hcnt        <= '0;
      vcnt        <= '0;
      bx          <= '0;
      by          <= '0;
      mode_r      <= 2'd0;
      started     <= 1'b0;
      FRAME       <= 16'd0;
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      DEN         <= ~DE_POL;
      XPOS        <= 10'd0;
      YPOS        <= 10'd0;
      LCD_R       <= 5'd0;
      LCD_G       <= 6'd0;
      LCD_B       <= 5'd0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      hcnt <= h_last ? '0 : hcnt + HW'(1);
      if (h_last) vcnt <= v_last ? '0 : vcnt + VW'(1);

      if (frame_first) begin
        mode_r  <= MODE;
        started <= 1'b1;
        if (started) FRAME <= FRAME + 16'd1;
      end

      // Box moves on the last clock of a frame so the new frame starts at the new spot
      if (h_last && v_last) begin
        bx <= (bx32 >= BX_MAX) ? '0 : bx + HW'(1);
        by <= (by32 >= BY_MAX) ? '0 : by + VW'(1);
      end

      HSYNC       <= hs_act  ? HS_POL : ~HS_POL;
      VSYNC       <= vs_act  ? VS_POL : ~VS_POL;
      DEN         <= den_act ? DE_POL : ~DE_POL;
      XPOS        <= den_act ? h[9:0] : 10'd0;
      YPOS        <= den_act ? v[9:0] : 10'd0;
      LCD_R       <= pix[15:11];
      LCD_G       <= pix[10:5];
      LCD_B       <= pix[4:0];
      LINE_START  <= (hcnt == '0);
      FRAME_START <= frame_first;
    end
  end

endmodule
